// File: rtl/dsp48_post_pkg.sv
// Shared constants for the DSP48A1-style post-adder/accumulator stage:
// operand-select codes, OPMODE bit positions and datapath widths.
package dsp48_post_pkg;
   localparam int P_W = 48;
   localparam int M_W = 36;

   localparam logic [1:0] X_ZERO = 2'd0;
   localparam logic [1:0] X_M    = 2'd1;
   localparam logic [1:0] X_P    = 2'd2;
   localparam logic [1:0] X_DAB  = 2'd3;

   localparam logic [1:0] Z_ZERO = 2'd0;
   localparam logic [1:0] Z_PCIN = 2'd1;
   localparam logic [1:0] Z_P    = 2'd2;
   localparam logic [1:0] Z_C    = 2'd3;

   localparam int OP_SUB = 7;
   localparam int OP_CIN = 5;
endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline register with asynchronous reset and clock enable;
// collapses to a plain wire when REG_EN is 0.
module dsp_pipe_reg #(
   parameter int WIDTH  = 1,
   parameter bit REG_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   generate
      if (REG_EN) begin : g_reg
         logic [WIDTH-1:0] q_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               q_reg <= '0;
            else if (ce)
               q_reg <= d;
         end
         assign q = q_reg;
      end else begin : g_bypass
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, rst, ce};
         assign q = d;
      end
   endgenerate
endmodule

// File: rtl/dsp_post_adder_acc.sv
// Post-adder/accumulator of a DSP48A1-style slice: X/Z operand muxes, 49-bit add/sub
// with carry-in, P/CARRYOUT registers. Optional sticky signed overflow via DSP_POSTADD_OVF_EN.
module dsp_post_adder_acc
   import dsp48_post_pkg::*;
#(
   parameter bit OPMODEREG   = 1'b1,
   parameter bit CARRYINREG  = 1'b1,
   parameter bit PREG        = 1'b1,
   parameter bit CARRYOUTREG = 1'b1,
   parameter     CARRYINSEL  = "OPMODE5"
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ce_opmode,
   input  logic           ce_carryin,
   input  logic           ce_p,
   input  logic [7:0]     opmode,
   input  logic [M_W-1:0] m,
   input  logic [P_W-1:0] dab,
   input  logic [P_W-1:0] c,
   input  logic [P_W-1:0] pcin,
   input  logic           carryin,
   output logic [P_W-1:0] p,
   output logic [P_W-1:0] pcout,
   output logic           carryout,
   output logic           carryoutf
`ifdef DSP_POSTADD_OVF_EN
   ,output logic          ovf
`endif
);
   logic [7:0]     opmode_r;
   logic           cin_sel;
   logic           cin_r;
   logic [1:0]     x_sel;
   logic [1:0]     z_sel;
   logic [P_W-1:0] p_fb;
   logic [P_W-1:0] x_mux;
   logic [P_W-1:0] z_mux;
   logic [P_W:0]   sum_next;
   logic           unused_opmode_bits;

   dsp_pipe_reg #(.WIDTH(8), .REG_EN(OPMODEREG)) u_opmode_reg (
      .clk(clk), .rst(rst), .ce(ce_opmode), .d(opmode), .q(opmode_r)
   );

   assign cin_sel = (CARRYINSEL == "CARRYIN") ? carryin : opmode_r[OP_CIN];

   dsp_pipe_reg #(.WIDTH(1), .REG_EN(CARRYINREG)) u_cin_reg (
      .clk(clk), .rst(rst), .ce(ce_carryin), .d(cin_sel), .q(cin_r)
   );

   assign x_sel = opmode_r[1:0];
   assign z_sel = opmode_r[3:2];
   assign unused_opmode_bits = ^{opmode_r[6], opmode_r[4]};

   // Without a P register the feedback path would be a combinational loop, so it reads as zero.
   assign p_fb = PREG ? p : '0;

   always_comb begin
      x_mux = '0;
      case (x_sel)
         X_M:     x_mux = {{(P_W-M_W){1'b0}}, m};
         X_P:     x_mux = p_fb;
         X_DAB:   x_mux = dab;
         default: x_mux = '0;
      endcase
   end

   always_comb begin
      z_mux = '0;
      case (z_sel)
         Z_PCIN:  z_mux = pcin;
         Z_P:     z_mux = p_fb;
         Z_C:     z_mux = c;
         default: z_mux = '0;
      endcase
   end

   always_comb begin
      sum_next = '0;
      if (opmode_r[OP_SUB])
         sum_next = {1'b0, z_mux} - ({1'b0, x_mux} + {{P_W{1'b0}}, cin_r});
      else
         sum_next = {1'b0, z_mux} + {1'b0, x_mux} + {{P_W{1'b0}}, cin_r};
   end

   dsp_pipe_reg #(.WIDTH(P_W), .REG_EN(PREG)) u_p_reg (
      .clk(clk), .rst(rst), .ce(ce_p), .d(sum_next[P_W-1:0]), .q(p)
   );

   dsp_pipe_reg #(.WIDTH(1), .REG_EN(CARRYOUTREG)) u_carryout_reg (
      .clk(clk), .rst(rst), .ce(ce_p), .d(sum_next[P_W]), .q(carryout)
   );

   assign pcout     = p;
   assign carryoutf = carryout;

`ifdef DSP_POSTADD_OVF_EN
   logic x_sign_eff;
   logic ovf_now;

   // For subtraction the effective X operand is negated, so its sign flips.
   assign x_sign_eff = opmode_r[OP_SUB] ? ~x_mux[P_W-1] : x_mux[P_W-1];
   assign ovf_now    = (z_mux[P_W-1] == x_sign_eff) && (sum_next[P_W-1] != z_mux[P_W-1]);

   generate
      if (PREG) begin : g_ovf
         logic ovf_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               ovf_reg <= 1'b0;
            else if (ce_p && ovf_now)
               ovf_reg <= 1'b1;
         end
         assign ovf = ovf_reg;
      end else begin : g_no_ovf
         assign ovf = 1'b0;
      end
   endgenerate
`endif

   generate
      if (!PREG) begin : g_no_preg_check
         feedback_without_preg: assert property (
            @(posedge clk) disable iff (rst) (x_sel != X_P) && (z_sel != Z_P));
      end
   endgenerate
endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Self-checking bench for dsp_post_adder_acc: directed scenarios plus randomized cycles
// compared against an arithmetic reference model of the default configuration.
module tb_dsp_post_adder_acc;
   logic        clk = 1'b0;
   logic        rst;
   logic        ce_opmode, ce_carryin, ce_p;
   logic [7:0]  opmode;
   logic [35:0] m;
   logic [47:0] dab, c, pcin;
   logic        carryin;
   logic [47:0] p, pcout;
   logic        carryout, carryoutf;
`ifdef DSP_POSTADD_OVF_EN
   logic        ovf;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state: what the slice has latched for opmode, carry-in, P and carry.
   logic [7:0]  mdl_op;
   logic        mdl_cin;
   logic [47:0] mdl_p;
   logic        mdl_co;
   logic        mdl_ovf;

   always #5 clk = ~clk;

   dsp_post_adder_acc dut (
      .clk(clk), .rst(rst), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin), .ce_p(ce_p),
      .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
      .p(p), .pcout(pcout), .carryout(carryout), .carryoutf(carryoutf)
`ifdef DSP_POSTADD_OVF_EN
      , .ovf(ovf)
`endif
   );

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic model_reset();
      mdl_op  = '0;
      mdl_cin = 1'b0;
      mdl_p   = '0;
      mdl_co  = 1'b0;
      mdl_ovf = 1'b0;
   endtask

   function automatic logic [48:0] pick_x(input logic [1:0] sel);
      case (sel)
         2'd1:    return {13'b0, m};
         2'd2:    return {1'b0, mdl_p};
         2'd3:    return {1'b0, dab};
         default: return 49'd0;
      endcase
   endfunction

   function automatic logic [48:0] pick_z(input logic [1:0] sel);
      case (sel)
         2'd1:    return {1'b0, pcin};
         2'd2:    return {1'b0, mdl_p};
         2'd3:    return {1'b0, c};
         default: return 49'd0;
      endcase
   endfunction

   task automatic model_edge();
      logic [48:0] xv, zv, res;
      logic        sx;
      xv = pick_x(mdl_op[1:0]);
      zv = pick_z(mdl_op[3:2]);
      if (ce_p) begin
         if (mdl_op[7])
            res = zv - xv - {48'd0, mdl_cin};
         else
            res = zv + xv + {48'd0, mdl_cin};
         sx = mdl_op[7] ? ~xv[47] : xv[47];
         if (zv[47] == sx && res[47] != zv[47])
            mdl_ovf = 1'b1;
         mdl_p  = res[47:0];
         mdl_co = res[48];
      end
      if (ce_carryin) mdl_cin = mdl_op[5];
      if (ce_opmode)  mdl_op  = opmode;
   endtask

   task automatic compare_outputs(input string tag);
      check({tag, ".p"}, p, mdl_p);
      check({tag, ".pcout"}, pcout, mdl_p);
      check({tag, ".carryout"}, {47'd0, carryout}, {47'd0, mdl_co});
      check({tag, ".carryoutf"}, {47'd0, carryoutf}, {47'd0, mdl_co});
`ifdef DSP_POSTADD_OVF_EN
      check({tag, ".ovf"}, {47'd0, ovf}, {47'd0, mdl_ovf});
`endif
   endtask

   task automatic cycle(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      compare_outputs(tag);
   endtask

   // Reset is pulsed between edges; outputs must clear before any clock arrives.
   task automatic rst_pulse(input string tag);
      #2 rst = 1'b1;
      #1;
      model_reset();
      compare_outputs(tag);
      check({tag, ".p_zero"}, p, 48'd0);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ce_opmode = 1'b1; ce_carryin = 1'b1; ce_p = 1'b1;
      opmode = 8'h00; m = '0; dab = '0; c = '0; pcin = '0; carryin = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_outputs("reset");
      rst = 1'b0;

      // Load p = 0x1234 via X=dab, then clear asynchronously.
      opmode = 8'h03; dab = 48'h1234;
      cycle("load0");
      cycle("load1");
      check("load_val", p, 48'h1234);
      rst_pulse("async_rst");

      // Multiply-accumulate p += m.
      opmode = 8'h09; m = 36'd5; dab = '0;
      cycle("mac_setup");
      for (int k = 1; k <= 4; k++) begin
         cycle("mac");
         check("mac_val", p, 48'(5 * k));
      end

      ce_p = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle("ce_hold");
         check("ce_hold_val", p, 48'd20);
      end
      ce_p = 1'b1;
      cycle("ce_resume");
      check("ce_resume_val", p, 48'd25);

      rst_pulse("rst_mid_mac");
      cycle("post_rst0");
      check("post_rst0_val", p, 48'd0);
      cycle("post_rst1");
      check("post_rst1_val", p, 48'd5);

      // Subtract Z=c minus X=m.
      opmode = 8'h8D; c = 48'd100; m = 36'd30; ce_p = 1'b0;
      cycle("sub_setup");
      ce_p = 1'b1;
      cycle("sub_pos");
      check("sub_pos_val", p, 48'd70);
      check("sub_pos_co", {47'd0, carryout}, 48'd0);
      c = 48'd10;
      cycle("sub_neg");
      check("sub_neg_val", p, 48'hFFFF_FFFF_FFEC);
      check("sub_neg_co", {47'd0, carryout}, 48'd1);

      // Carry-in wraps all-ones to zero; carry-in path lags opmode by one register.
      opmode = 8'h2F; c = 48'hFFFF_FFFF_FFFF; dab = '0; ce_p = 1'b0;
      cycle("wrap_setup0");
      cycle("wrap_setup1");
      ce_p = 1'b1;
      cycle("wrap");
      check("wrap_val", p, 48'd0);
      check("wrap_co", {47'd0, carryout}, 48'd1);

`ifdef DSP_POSTADD_OVF_EN
      opmode = 8'h0F; c = 48'h7FFF_FFFF_FFFF; dab = 48'd1; ce_p = 1'b0;
      cycle("ovf_setup0");
      cycle("ovf_setup1");
      ce_p = 1'b1;
      cycle("ovf_set");
      check("ovf_set_val", {47'd0, ovf}, 48'd1);
      c = '0; dab = '0;
      cycle("ovf_sticky");
      check("ovf_sticky_val", {47'd0, ovf}, 48'd1);
      rst_pulse("ovf_clear");
`endif

      for (int i = 0; i < 300; i++) begin
         opmode     = 8'($urandom);
         ce_opmode  = ($urandom_range(0, 3) != 0);
         ce_carryin = ($urandom_range(0, 3) != 0);
         ce_p       = ($urandom_range(0, 3) != 0);
         m          = 36'({$urandom, $urandom});
         dab        = 48'({$urandom, $urandom});
         c          = 48'({$urandom, $urandom});
         pcin       = 48'({$urandom, $urandom});
         carryin    = 1'($urandom);
         if ($urandom_range(0, 39) == 0)
            rst_pulse("rand_rst");
         else
            cycle("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
